// File: rtl/axi_read_resp.sv
// AXI read-channel responder: queues AR requests in order and returns R bursts
// whose data is the beat address replicated across the bus, after a fixed latency.
module axi_read_resp #(
    parameter int AR_DEPTH = 4,
    parameter int LAT      = 2
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic [6:0]   arid,
    input  logic [31:0]  araddr,
    input  logic [7:0]   arlen,
    input  logic [2:0]   arsize,
    input  logic [1:0]   arburst,
    input  logic         arvalid,
    output logic         arready,
    output logic [6:0]   rid,
    output logic [255:0] rdata,
    output logic [1:0]   rresp,
    output logic         rlast,
    output logic         rvalid,
    input  logic         rready
);

    localparam int PW = $clog2(AR_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(AR_DEPTH);
    localparam logic [3:0]    LAT_M1  = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [6:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step;
        logic [31:0] w;
        step = 32'd1 << size;
        w    = (32'(len) + 32'd1) << size;
        case (burst)
            BURST_INCR: next_addr = a + step;
            BURST_WRAP: next_addr = (a & ~(w - 32'd1)) | ((a + step) & (w - 32'd1));
            default:    next_addr = a;
        endcase
    endfunction

    function automatic logic decode_err(input ar_t e);
        logic wrap_len_ok;
        wrap_len_ok = (e.len == 8'd1) || (e.len == 8'd3) || (e.len == 8'd7) || (e.len == 8'd15);
        decode_err  = (e.burst == 2'b11) || (e.size > 3'd5) ||
                      ((e.burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

    function automatic logic [255:0] beat_data(input logic [31:0] a, input logic err);
        beat_data = err ? '0 : {8{a}};
    endfunction

    ar_t           mem_q [AR_DEPTH];
    ar_t           in_req, head;
    logic          head_err, push, pop;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [7:0]    beat_q, beat_d, len_q, len_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    burst_q, burst_d;
    logic          err_q, err_d;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [6:0]    rid_q, rid_d;
    logic [255:0]  rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;

    assign in_req   = '{id: arid, addr: araddr, len: arlen, size: arsize, burst: arburst};
    assign head     = mem_q[rd_ptr_q];
    assign head_err = decode_err(head);
    assign push     = arvalid && arready_q;
    assign pop      = (state_q == S_IDLE) && (count_q != '0);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        err_d     = err_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Registered from the post-update count, so a full queue refuses a push
        // even in the cycle its head is popped.
        arready_d = (count_d < DEPTH_C);

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    addr_d  = head.addr;
                    len_d   = head.len;
                    size_d  = head.size;
                    burst_d = head.burst;
                    err_d   = head_err;
                    beat_d  = 8'd0;
                    rid_d   = head.id;
                    rresp_d = head_err ? RESP_SLVERR : RESP_OKAY;
                    rdata_d = beat_data(head.addr, head_err);
                    rlast_d = (head.len == 8'd0);
                    if (LAT > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = LAT_M1;
                    end else begin
                        state_d  = S_BURST;
                        rvalid_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = S_BURST;
                    rvalid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_BURST: begin
                if (rvalid_q && rready) begin
                    if (beat_q == len_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        state_d  = S_IDLE;
                    end else begin
                        addr_d  = next_addr(addr_q, len_q, size_q, burst_q);
                        rdata_d = beat_data(addr_d, err_q);
                        beat_d  = beat_q + 8'd1;
                        rlast_d = ((beat_q + 8'd1) == len_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: queue storage carries no reset; entries are only read once count marks them valid.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= in_req;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 32'd0;
            beat_q    <= 8'd0;
            len_q     <= 8'd0;
            size_q    <= 3'd0;
            burst_q   <= BURST_FIXED;
            err_q     <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= 7'd0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            beat_q    <= beat_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            err_q     <= err_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_read_resp.sv
// Scoreboard bench for axi_read_resp: directed AR requests push hand-computed
// R beats; a negedge monitor pops and compares every accepted beat.
module tb_axi_read_resp;

    localparam int AR_DEPTH = 4;
    localparam int LAT      = 2;

    logic         i_clk = 1'b0;
    logic         i_reset_n;
    logic [6:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [6:0]   rid;
    logic [255:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    axi_read_resp #(.AR_DEPTH(AR_DEPTH), .LAT(LAT)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [6:0]   id;
        logic [1:0]   resp;
        logic         last;
        logic [255:0] data;
    } beat_t;

    beat_t sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    last_hs = 0;
    int    first_rv_cyc = 0;
    logic  rv_prev = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [299:0] got, input logic [299:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic exp_beat(input logic [6:0] id, input logic [31:0] word,
                            input logic [1:0] resp, input logic last);
        beat_t b;
        b.id   = id;
        b.resp = resp;
        b.last = last;
        b.data = {8{word}};
        sb.push_back(b);
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic send_ar(input logic [6:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit ok;
        ok      = 1'b0;
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arsize  = size;
        arburst = burst;
        arvalid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge i_clk);
            if (arready) begin
                ok = 1'b1;
                last_hs = cyc;
                break;
            end
        end
        if (!ok) check("ar_handshake_timeout", 300'(arready), 300'd1);
        @(posedge i_clk);
        #1 arvalid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge i_clk);
            if (sb.size() == 0 && !rvalid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("drain_timeout", 300'(sb.size()), 300'd0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_rvalid();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (rvalid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("rvalid_timeout", 300'(rvalid), 300'd1);
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (rvalid && !rv_prev) first_rv_cyc = cyc;
            if (rvalid && rready) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 300'(rvalid), 300'd0);
                end else begin
                    beat_t e;
                    beat_t g;
                    e = sb.pop_front();
                    g = '{id: rid, resp: rresp, last: rlast, data: rdata};
                    check("r_beat", 300'(g), 300'(e));
                end
            end
        end
        rv_prev = rvalid;
    end

    initial begin
        logic [266:0] snap;
        int           stray;
        i_reset_n = 1'b0;
        rready    = 1'b1;
        arvalid   = 1'b0;
        arid      = '0;
        araddr    = '0;
        arlen     = '0;
        arsize    = '0;
        arburst   = '0;

        #1 check("reset_outputs", 300'({arready, rvalid, rlast, rid, rresp, rdata}), 300'd0);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk) i_reset_n = 1'b1;
        check("arready_held_until_edge", 300'(arready), 300'd0);
        @(negedge i_clk);
        check("arready_after_release", 300'(arready), 300'd1);
        @(posedge i_clk);
        #1;

        // Single INCR, size 5: addresses step by 32 bytes
        exp_beat(7'h15, 32'h1000, 2'b00, 1'b0);
        exp_beat(7'h15, 32'h1020, 2'b00, 1'b0);
        exp_beat(7'h15, 32'h1040, 2'b00, 1'b0);
        exp_beat(7'h15, 32'h1060, 2'b00, 1'b1);
        send_ar(7'h15, 32'h1000, 8'd3, 3'd5, 2'b01);
        drain();
        check("first_rvalid_latency", 300'(first_rv_cyc - last_hs), 300'(2 + LAT));

        // WRAP 4 x 16 bytes from 0x1030 wraps inside the 64-byte window
        exp_beat(7'h02, 32'h1030, 2'b00, 1'b0);
        exp_beat(7'h02, 32'h1000, 2'b00, 1'b0);
        exp_beat(7'h02, 32'h1010, 2'b00, 1'b0);
        exp_beat(7'h02, 32'h1020, 2'b00, 1'b1);
        send_ar(7'h02, 32'h1030, 8'd3, 3'd4, 2'b10);
        // FIXED keeps the same address
        exp_beat(7'h03, 32'h2000, 2'b00, 1'b0);
        exp_beat(7'h03, 32'h2000, 2'b00, 1'b0);
        exp_beat(7'h03, 32'h2000, 2'b00, 1'b1);
        send_ar(7'h03, 32'h2000, 8'd2, 3'd2, 2'b00);

        // Error bursts: reserved burst type, oversize beat, illegal wrap length
        exp_beat(7'h04, 32'h0, 2'b10, 1'b0);
        exp_beat(7'h04, 32'h0, 2'b10, 1'b1);
        send_ar(7'h04, 32'h3000, 8'd1, 3'd2, 2'b11);
        exp_beat(7'h05, 32'h0, 2'b10, 1'b1);
        send_ar(7'h05, 32'h3100, 8'd0, 3'd6, 2'b01);
        exp_beat(7'h06, 32'h0, 2'b10, 1'b0);
        exp_beat(7'h06, 32'h0, 2'b10, 1'b0);
        exp_beat(7'h06, 32'h0, 2'b10, 1'b1);
        send_ar(7'h06, 32'h3200, 8'd2, 3'd2, 2'b10);
        exp_beat(7'h07, 32'h4000, 2'b00, 1'b1);
        send_ar(7'h07, 32'h4000, 8'd0, 3'd2, 2'b01);

        // INCR across the top of the 32-bit space
        exp_beat(7'h08, 32'hFFFF_FFE0, 2'b00, 1'b0);
        exp_beat(7'h08, 32'h0000_0000, 2'b00, 1'b1);
        send_ar(7'h08, 32'hFFFF_FFE0, 8'd1, 3'd5, 2'b01);
        drain();

        // Backpressure for 5 cycles on beat 2
        rready = 1'b0;
        exp_beat(7'h09, 32'h3000, 2'b00, 1'b0);
        exp_beat(7'h09, 32'h3004, 2'b00, 1'b0);
        exp_beat(7'h09, 32'h3008, 2'b00, 1'b0);
        exp_beat(7'h09, 32'h300C, 2'b00, 1'b1);
        send_ar(7'h09, 32'h3000, 8'd3, 3'd2, 2'b01);
        wait_rvalid();
        @(posedge i_clk) #1 rready = 1'b1;
        @(posedge i_clk) #1 rready = 1'b0;
        @(negedge i_clk) snap = {rvalid, rid, rresp, rlast, rdata};
        repeat (5) @(negedge i_clk);
        check("stall_hold", 300'({rvalid, rid, rresp, rlast, rdata}), 300'(snap));
        check("stall_beat2_data", 300'(rdata), 300'({8{32'h3004}}));
        @(posedge i_clk) #1 rready = 1'b1;
        drain();

        // Queue full: one burst in service plus AR_DEPTH queued blocks a 6th request
        rready = 1'b0;
        for (int i = 1; i <= 6; i++) exp_beat(7'(i), 32'(i * 256), 2'b00, 1'b1);
        for (int i = 1; i <= 5; i++) send_ar(7'(i), 32'(i * 256), 8'd0, 3'd2, 2'b01);
        check("arready_full", 300'(arready), 300'd0);
        repeat (5) @(posedge i_clk);
        #1 check("arready_stays_full", 300'(arready), 300'd0);
        fork
            send_ar(7'd6, 32'd1536, 8'd0, 3'd2, 2'b01);
            begin
                repeat (3) @(posedge i_clk);
                #1 rready = 1'b1;
            end
        join
        drain();

        // Reset during beat 2 of an 8-beat burst with two requests queued
        rready = 1'b0;
        exp_beat(7'h20, 32'h5000, 2'b00, 1'b0);
        send_ar(7'h20, 32'h5000, 8'd7, 3'd2, 2'b01);
        send_ar(7'h21, 32'h5100, 8'd0, 3'd2, 2'b01);
        send_ar(7'h22, 32'h5200, 8'd0, 3'd2, 2'b01);
        wait_rvalid();
        @(posedge i_clk) #1 rready = 1'b1;
        @(posedge i_clk) #1 rready = 1'b0;
        #2 i_reset_n = 1'b0;
        #1 check("reset_mid_burst", 300'({rvalid, arready, rlast, rid, rresp, rdata}), 300'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk) i_reset_n = 1'b1;
        rready = 1'b1;
        stray = 0;
        repeat (30) begin
            @(negedge i_clk);
            if (rvalid) stray++;
        end
        check("no_beats_after_reset", 300'(stray), 300'd0);
        check("scoreboard_empty_after_reset", 300'(sb.size()), 300'd0);
        @(posedge i_clk);
        #1;
        exp_beat(7'h23, 32'h6000, 2'b00, 1'b1);
        send_ar(7'h23, 32'h6000, 8'd0, 3'd2, 2'b01);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
